// File: rtl/uart_spi_pkg.sv
// -----------------------------------------------------------------------------
// uart_spi_pkg
//   Shared definitions for the UART-to-SPI command sequencer:
//     - seq_state_t        : sequencer FSM states
//     - CMD_* constants    : command byte field positions
//     - DEFAULT_* params   : default watchdog limit and chip-select gap length
//     - is_wait_state()    : states in which the watchdog is allowed to count
// -----------------------------------------------------------------------------
package uart_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        SPI_GO,
        SPI_WAIT,
        RESP_WAIT,
        RESP_ACK,
        CS_GAP
    } seq_state_t;

    // Command byte layout: bit7 = RD, bits[6:4] reserved, bits[3:0] = LEN.
    localparam int CMD_RD_BIT  = 7;
    localparam int CMD_LEN_MSB = 3;
    localparam int CMD_LEN_LSB = 0;
    localparam int LEN_W       = CMD_LEN_MSB - CMD_LEN_LSB + 1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4095;
    localparam int DEFAULT_CS_GAP_CYCLES  = 4;

    // States that wait on an external event and can therefore stall.
    function automatic logic is_wait_state(input seq_state_t s);
        return s inside {GET_DATA, SPI_WAIT, RESP_WAIT, RESP_ACK};
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
//   Saturating cycle counter used to abort stalled frames.
//   Ports:
//     clk      in  system clock
//     reset    in  synchronous active-high reset
//     clear    in  zero the counter (takes priority over enable)
//     enable   in  count one cycle
//     expired  out counter has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module seq_watchdog
    import uart_spi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/uart_spi_cmd_seq.sv
// -----------------------------------------------------------------------------
// uart_spi_cmd_seq
//   Command sequencer between a UART byte interface and an SPI master byte
//   interface. A host frame is one command byte (RD flag + LEN) followed by
//   LEN payload bytes; each payload byte becomes one SPI transfer inside a
//   single chip-select window. With RD set, every SPI-received byte is sent
//   back over UART. A watchdog aborts frames that stall in any wait state.
//
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     rx_valid, rx_data        UART receive byte strobe and data
//     tx_ready                 UART transmitter idle
//     tx_start, tx_data        UART transmit strobe and byte
//     spi_start, spi_tx_data   SPI transfer strobe and byte to shift out
//     spi_cs_bar               SPI chip select, active low
//     spi_done, spi_rx_data    SPI transfer complete strobe and received byte
//     busy                     sequencer not idle
//     err_timeout              sticky: last frame aborted by watchdog
//     err_overrun              sticky: UART byte arrived while not accepting
// -----------------------------------------------------------------------------
module uart_spi_cmd_seq
    import uart_spi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CS_GAP_CYCLES  = DEFAULT_CS_GAP_CYCLES,
    parameter int DW             = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    input  logic          tx_ready,
    output logic          tx_start,
    output logic [DW-1:0] tx_data,
    output logic          spi_start,
    output logic [DW-1:0] spi_tx_data,
    output logic          spi_cs_bar,
    input  logic          spi_done,
    input  logic [DW-1:0] spi_rx_data,
    output logic          busy,
    output logic          err_timeout,
    output logic          err_overrun
);

    localparam int GAP_W = $clog2(CS_GAP_CYCLES + 1);

    seq_state_t       state;
    seq_state_t       next_state;

    logic             rd_flag;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] remaining_dec;
    logic [LEN_W-1:0] cmd_len;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_done;

    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;

    logic             accept_cmd;
    logic             accept_data;
    logic             spi_byte_done;
    logic             timeout_abort;
    logic             overrun_hit;

    assign cmd_len       = rx_data[CMD_LEN_MSB:CMD_LEN_LSB];
    // Down-count that holds at zero rather than wrapping.
    assign remaining_dec = (remaining != '0) ? remaining - 1'b1 : '0;
    assign gap_done      = (gap_cnt == GAP_W'(CS_GAP_CYCLES - 1));

    // Only IDLE (command) and GET_DATA (payload) consume UART bytes.
    assign overrun_hit   = rx_valid && !(state inside {IDLE, GET_DATA});

    assign busy          = (state != IDLE);

    // Watchdog restarts on every state change and only runs while waiting.
    assign wd_clear      = (next_state != state);
    assign wd_enable     = is_wait_state(state);

    seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        next_state    = state;
        spi_start     = 1'b0;
        tx_start      = 1'b0;
        accept_cmd    = 1'b0;
        accept_data   = 1'b0;
        spi_byte_done = 1'b0;
        timeout_abort = 1'b0;

        case (state)
            IDLE: begin
                // LEN=0 commands are swallowed without starting a frame.
                if (rx_valid && (cmd_len != '0)) begin
                    accept_cmd = 1'b1;
                    next_state = GET_DATA;
                end
            end

            GET_DATA: begin
                if (wd_expired) begin
                    timeout_abort = 1'b1;
                    next_state    = CS_GAP;
                end else if (rx_valid) begin
                    accept_data = 1'b1;
                    next_state  = SPI_GO;
                end
            end

            SPI_GO: begin
                spi_start  = 1'b1;
                next_state = SPI_WAIT;
            end

            SPI_WAIT: begin
                // A completing transfer beats a watchdog expiry in the same cycle.
                if (spi_done) begin
                    spi_byte_done = 1'b1;
                    if (rd_flag) begin
                        next_state = RESP_WAIT;
                    end else if (remaining_dec != '0) begin
                        next_state = GET_DATA;
                    end else begin
                        next_state = CS_GAP;
                    end
                end else if (wd_expired) begin
                    timeout_abort = 1'b1;
                    next_state    = CS_GAP;
                end
            end

            RESP_WAIT: begin
                if (wd_expired) begin
                    timeout_abort = 1'b1;
                    next_state    = CS_GAP;
                end else if (tx_ready) begin
                    tx_start   = 1'b1;
                    next_state = RESP_ACK;
                end
            end

            RESP_ACK: begin
                // Wait for the transmitter to go busy so the same byte is not
                // launched twice while tx_ready is still reporting idle.
                if (wd_expired) begin
                    timeout_abort = 1'b1;
                    next_state    = CS_GAP;
                end else if (!tx_ready) begin
                    next_state = (remaining != '0) ? GET_DATA : CS_GAP;
                end
            end

            CS_GAP: begin
                if (gap_done) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath, chip select and sticky error flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_flag     <= 1'b0;
            remaining   <= '0;
            spi_tx_data <= '0;
            tx_data     <= '0;
            spi_cs_bar  <= 1'b1;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            if (accept_cmd) begin
                rd_flag     <= rx_data[CMD_RD_BIT];
                remaining   <= cmd_len;
                err_timeout <= 1'b0;
                err_overrun <= 1'b0;
            end

            if (accept_data) begin
                spi_tx_data <= rx_data;
            end

            if (spi_byte_done) begin
                remaining <= remaining_dec;
                // tx_data is loaded here so it is already valid when tx_start
                // fires in the following RESP_WAIT cycle.
                if (rd_flag) begin
                    tx_data <= spi_rx_data;
                end
            end

            if (timeout_abort) begin
                err_timeout <= 1'b1;
            end

            if (overrun_hit) begin
                err_overrun <= 1'b1;
            end

            gap_cnt <= (state == CS_GAP) ? gap_cnt + 1'b1 : '0;

            // Chip select follows the state transition on the same edge: it
            // drops entering the first SPI_GO and rises when the frame ends.
            if (next_state == SPI_GO) begin
                spi_cs_bar <= 1'b0;
            end else if (next_state inside {CS_GAP, IDLE}) begin
                spi_cs_bar <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_spi_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_uart_spi_cmd_seq
//   Directed self-checking bench for uart_spi_cmd_seq. Inputs are driven 1 ns
//   after each rising edge and outputs are sampled at the same point, so every
//   observation reflects the state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_uart_spi_cmd_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       spi_cs_bar;
    logic       spi_done;
    logic [7:0] spi_rx_data;
    logic       busy;
    logic       err_timeout;
    logic       err_overrun;

    int checks        = 0;
    int errors        = 0;
    int spi_start_cnt = 0;
    int tx_start_cnt  = 0;
    int spi_base;
    int tx_base;
    int cs_high;

    uart_spi_cmd_seq dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_cs_bar  (spi_cs_bar),
        .spi_done    (spi_done),
        .spi_rx_data (spi_rx_data),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    initial forever #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and tally strobes seen in the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (spi_start === 1'b1) spi_start_cnt++;
        if (tx_start === 1'b1) tx_start_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Called in the SPI_GO cycle: completes the transfer 16 cycles after
    // spi_start, counting any cycle where chip select is not held low.
    task automatic spi_reply(input logic [7:0] b, output int cs_hi);
        cs_hi = 0;
        repeat (15) begin
            tick();
            if (spi_cs_bar !== 1'b0) cs_hi++;
        end
        spi_done    = 1'b1;
        spi_rx_data = b;
        tick();
        spi_done = 1'b0;
    endtask

    // Called in the first CS_GAP cycle: gap lasts 4 cycles, then IDLE.
    task automatic gap_check(input string tag);
        repeat (3) tick();
        check1({tag, "_gap_busy"}, busy, 1'b1);
        check1({tag, "_gap_cs"}, spi_cs_bar, 1'b1);
        tick();
        check1({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tx_ready    = 1'b1;
        spi_done    = 1'b0;
        spi_rx_data = 8'h00;
        tick();
        tick();

        // ---------------- reset state ----------------
        check1("rst_cs", spi_cs_bar, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_spi_start", spi_start, 1'b0);
        check1("rst_tx_start", tx_start, 1'b0);
        check1("rst_err_to", err_timeout, 1'b0);
        check1("rst_err_ov", err_overrun, 1'b0);
        check8("rst_tx_data", tx_data, 8'h00);
        check8("rst_spi_tx", spi_tx_data, 8'h00);
        reset = 1'b0;
        tick();

        // ---------------- write frame: 0x02, A5, 3C ----------------
        spi_base = spi_start_cnt;
        tx_base  = tx_start_cnt;
        send_byte(8'h02);
        check1("wr_busy", busy, 1'b1);
        check1("wr_cs_pre", spi_cs_bar, 1'b1);
        send_byte(8'hA5);
        check1("wr_start0", spi_start, 1'b1);
        check8("wr_data0", spi_tx_data, 8'hA5);
        check1("wr_cs_low0", spi_cs_bar, 1'b0);
        spi_reply(8'h11, cs_high);
        check_int("wr_cs_hold0", cs_high, 0);
        check1("wr_cs_between", spi_cs_bar, 1'b0);
        send_byte(8'h3C);
        check1("wr_start1", spi_start, 1'b1);
        check8("wr_data1", spi_tx_data, 8'h3C);
        spi_reply(8'h22, cs_high);
        check_int("wr_cs_hold1", cs_high, 0);
        check1("wr_cs_rise", spi_cs_bar, 1'b1);
        repeat (3) tick();
        check1("wr_gap_busy", busy, 1'b1);
        // Byte arriving in the last gap cycle is dropped as an overrun.
        send_byte(8'h81);
        check1("wr_idle", busy, 1'b0);
        check1("gap_edge_overrun", err_overrun, 1'b1);
        check_int("wr_spi_starts", spi_start_cnt - spi_base, 2);
        check_int("wr_no_tx", tx_start_cnt - tx_base, 0);

        // ---------------- LEN = 0 ----------------
        spi_base = spi_start_cnt;
        tx_base  = tx_start_cnt;
        send_byte(8'h80);
        check1("len0_busy", busy, 1'b0);
        check1("len0_cs", spi_cs_bar, 1'b1);
        check1("len0_keep_err", err_overrun, 1'b1);
        repeat (3) tick();
        check1("len0_busy_later", busy, 1'b0);
        check_int("len0_no_pulses", (spi_start_cnt - spi_base) + (tx_start_cnt - tx_base), 0);

        // ---------------- read frame: 0x81, 55 -> C3 ----------------
        spi_base = spi_start_cnt;
        tx_base  = tx_start_cnt;
        send_byte(8'h81);
        check1("rd_clr_overrun", err_overrun, 1'b0);
        send_byte(8'h55);
        check1("rd_start", spi_start, 1'b1);
        check8("rd_spi_data", spi_tx_data, 8'h55);
        spi_reply(8'hC3, cs_high);
        check1("rd_tx_start", tx_start, 1'b1);
        check8("rd_tx_data", tx_data, 8'hC3);
        repeat (4) tick();
        check1("rd_hold_busy", busy, 1'b1);
        check1("rd_hold_cs", spi_cs_bar, 1'b0);
        check_int("rd_single_tx", tx_start_cnt - tx_base, 1);
        tx_ready = 1'b0;
        tick();
        check1("rd_cs_rise", spi_cs_bar, 1'b1);
        tx_ready = 1'b1;
        gap_check("rd");
        check8("rd_tx_data_hold", tx_data, 8'hC3);
        check_int("rd_single_tx_end", tx_start_cnt - tx_base, 1);

        // ---------------- timeout in GET_DATA ----------------
        spi_base = spi_start_cnt;
        send_byte(8'h01);
        repeat (4095) tick();
        check1("to_not_yet", err_timeout, 1'b0);
        check1("to_still_busy", busy, 1'b1);
        tick();
        check1("to_set", err_timeout, 1'b1);
        check1("to_cs", spi_cs_bar, 1'b1);
        gap_check("to");
        check_int("to_no_spi", spi_start_cnt - spi_base, 0);
        send_byte(8'h01);
        check1("to_clear", err_timeout, 1'b0);

        // ---------------- overrun during SPI_WAIT ----------------
        spi_base = spi_start_cnt;
        send_byte(8'h5A);
        check1("ov_start", spi_start, 1'b1);
        tick();
        send_byte(8'hEE);
        check1("ov_set", err_overrun, 1'b1);
        check8("ov_dropped", spi_tx_data, 8'h5A);
        repeat (10) tick();
        spi_done    = 1'b1;
        spi_rx_data = 8'h12;
        tick();
        spi_done = 1'b0;
        check1("ov_frame_end", spi_cs_bar, 1'b1);
        gap_check("ov");
        check1("ov_sticky", err_overrun, 1'b1);
        check_int("ov_one_xfer", spi_start_cnt - spi_base, 1);

        // ---------------- spi_done coincident with watchdog expiry ----------------
        send_byte(8'h01);
        send_byte(8'h6B);
        tick();
        repeat (4095) tick();
        check1("race_cs_low", spi_cs_bar, 1'b0);
        spi_done    = 1'b1;
        spi_rx_data = 8'h34;
        tick();
        spi_done = 1'b0;
        check1("race_no_timeout", err_timeout, 1'b0);
        check1("race_cs_rise", spi_cs_bar, 1'b1);
        gap_check("race");

        // ---------------- reset during SPI_WAIT ----------------
        send_byte(8'h83);
        send_byte(8'h99);
        tick();
        send_byte(8'hEE);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check1("mrst_cs", spi_cs_bar, 1'b1);
        check1("mrst_busy", busy, 1'b0);
        check1("mrst_spi_start", spi_start, 1'b0);
        check1("mrst_tx_start", tx_start, 1'b0);
        check1("mrst_err_ov", err_overrun, 1'b0);
        check8("mrst_spi_tx", spi_tx_data, 8'h00);
        check8("mrst_tx_data", tx_data, 8'h00);
        reset    = 1'b0;
        spi_base = spi_start_cnt;
        tx_base  = tx_start_cnt;
        repeat (5) tick();
        check_int("mrst_no_pulses", (spi_start_cnt - spi_base) + (tx_start_cnt - tx_base), 0);

        // ---------------- frame after reset: 0x81, 3C -> 96 ----------------
        send_byte(8'h81);
        send_byte(8'h3C);
        check1("post_start", spi_start, 1'b1);
        check8("post_spi_data", spi_tx_data, 8'h3C);
        check1("post_cs_low", spi_cs_bar, 1'b0);
        spi_reply(8'h96, cs_high);
        check_int("post_cs_hold", cs_high, 0);
        check1("post_tx_start", tx_start, 1'b1);
        check8("post_tx_data", tx_data, 8'h96);
        tick();
        tx_ready = 1'b0;
        tick();
        check1("post_cs_rise", spi_cs_bar, 1'b1);
        tx_ready = 1'b1;
        gap_check("post");
        check_int("post_spi_starts", spi_start_cnt - spi_base, 1);
        check_int("post_tx_starts", tx_start_cnt - tx_base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
